alarm_zone_ctrl: RTL and testbench

- Parametrised multi-zone intruder-alarm controller; successor to the fixed 3-sensor siren top level.
- Contains:
  - its own tick divider;
  - per-zone input synchronisers;
  - instant and delayed zone classes;
  - exit, entry and siren timers in tick units;
  - a coded keypad arm/disarm;
  - latched zone indication;
  - automatic re-arm with bypass of zones still open after the siren timeout.
- Sits directly between board I/O (sensors, keypad decoder) and the indicator/siren drivers.

---
 rtl/alarm_zone_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_alarm_zone_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_zone_ctrl.sv
// Multi-zone intruder-alarm controller: tick divider, zone synchronisers, exit/entry/siren timers,
// keypad arm/disarm, latched zones and auto re-arm with bypass. Optional tamper input: ALARM_TAMPER_EN.
module alarm_zone_ctrl #(
  parameter int unsigned          NUM_ZONES    = 3,
  parameter int unsigned          CLK_DIV      = 2500000,
  parameter int unsigned          CODE_W       = 4,
  parameter logic [CODE_W-1:0]    ARM_CODE     = 4'hA,
  parameter logic [NUM_ZONES-1:0] INSTANT_MASK = 3'b001,
  parameter int unsigned          TIMER_W      = 8,
  parameter int unsigned          EXIT_DELAY   = 10,
  parameter int unsigned          ENTRY_DELAY  = 10,
  parameter int unsigned          SIREN_TIME   = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_ZONES-1:0] sensors_in,
  input  logic                 keypad_valid,
  input  logic [CODE_W-1:0]    keypad_code,
`ifdef ALARM_TAMPER_EN
  input  logic                 tamper_in,
`endif
  output logic                 alarm_siren,
  output logic                 is_armed,
  output logic                 is_wait_delay,
  output logic [NUM_ZONES-1:0] zone_latched,
  output logic                 tick
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0]    DivMax  = DivW'(CLK_DIV - 1);
  localparam logic [TIMER_W-1:0] ExitLd  = TIMER_W'(EXIT_DELAY);
  localparam logic [TIMER_W-1:0] EntryLd = TIMER_W'(ENTRY_DELAY);
  localparam logic [TIMER_W-1:0] SirenLd = TIMER_W'(SIREN_TIME);
  localparam logic [TIMER_W-1:0] TimerOne = TIMER_W'(1);

  typedef enum logic [2:0] {
    StDisarmed,
    StExitWait,
    StArmed,
    StEntryWait,
    StAlarm
  } state_e;

  state_e               r_state, w_state_nxt;
  logic [DivW-1:0]      r_div;
  logic [TIMER_W-1:0]   r_timer, w_timer_nxt;
  logic [NUM_ZONES-1:0] r_sens_s1, r_sens_s2;
  logic [NUM_ZONES-1:0] r_bypass, w_bypass_nxt;
  logic [NUM_ZONES-1:0] r_latched, w_latch_nxt;
  logic                 r_siren, r_armed, r_wait;

  logic                 w_tick;
  logic                 w_code_match;
  logic [NUM_ZONES-1:0] w_active;
  logic                 w_inst_trip;
  logic                 w_dly_trip;
  logic                 w_expire;

  // Free-running divider; arming does not restart it, so the first tick period may be partial.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (r_div == DivMax) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_tick = (r_div == DivMax);
  assign tick   = w_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sens_s1 <= '0;
      r_sens_s2 <= '0;
    end else begin
      r_sens_s1 <= sensors_in;
      r_sens_s2 <= r_sens_s1;
    end
  end

`ifdef ALARM_TAMPER_EN
  logic r_tamp_s1, r_tamp_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tamp_s1 <= 1'b0;
      r_tamp_s2 <= 1'b0;
    end else begin
      r_tamp_s1 <= tamper_in;
      r_tamp_s2 <= r_tamp_s1;
    end
  end
`endif

  assign w_code_match = keypad_valid && (keypad_code == ARM_CODE);
  assign w_active     = r_sens_s2 & ~r_bypass;
  assign w_inst_trip  = |(w_active & INSTANT_MASK);
  assign w_dly_trip   = |(w_active & ~INSTANT_MASK);
  assign w_expire     = w_tick && (r_timer == TimerOne);

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_bypass_nxt = r_bypass & r_sens_s2;  // a bypassed zone goes live once it reads closed
    w_latch_nxt  = r_latched;
    case (r_state)
      StDisarmed: begin
        if (w_code_match) begin
          w_state_nxt  = StExitWait;
          w_timer_nxt  = ExitLd;
          w_latch_nxt  = '0;
          w_bypass_nxt = '0;
        end
      end
      StExitWait: begin
        if (w_code_match) begin
          w_state_nxt = StDisarmed;
        end else if (w_tick) begin
          w_timer_nxt = r_timer - 1'b1;
          if (w_expire) w_state_nxt = StArmed;
        end
      end
      StArmed: begin
        w_latch_nxt = r_latched | w_active;
        if (w_code_match) begin
          w_state_nxt = StDisarmed;
        end else if (w_inst_trip) begin
          w_state_nxt = StAlarm;
          w_timer_nxt = SirenLd;
        end else if (w_dly_trip) begin
          w_state_nxt = StEntryWait;
          w_timer_nxt = EntryLd;
        end
      end
      StEntryWait: begin
        w_latch_nxt = r_latched | w_active;
        if (w_code_match) begin
          w_state_nxt = StDisarmed;
        end else if (w_inst_trip) begin
          w_state_nxt = StAlarm;
          w_timer_nxt = SirenLd;
        end else if (w_tick) begin
          w_timer_nxt = r_timer - 1'b1;
          if (w_expire) begin
            w_state_nxt = StAlarm;
            w_timer_nxt = SirenLd;
          end
        end
      end
      StAlarm: begin
        w_latch_nxt  = r_latched | w_active;
        w_bypass_nxt = r_sens_s2;  // zones still open at timeout stay bypassed after re-arm
        if (w_code_match) begin
          w_state_nxt = StDisarmed;
        end else if (w_tick) begin
          w_timer_nxt = r_timer - 1'b1;
          if (w_expire) w_state_nxt = StArmed;
        end
      end
      default: begin
        w_state_nxt = StDisarmed;
      end
    endcase
`ifdef ALARM_TAMPER_EN
    // Tamper outranks the keypad, so a disarmed-state code must not clear latches either.
    if (r_tamp_s2) begin
      w_state_nxt = StAlarm;
      w_timer_nxt = SirenLd;
      if (r_state == StDisarmed) begin
        w_latch_nxt  = r_latched;
        w_bypass_nxt = r_bypass & r_sens_s2;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StDisarmed;
      r_timer   <= '0;
      r_bypass  <= '0;
      r_latched <= '0;
      r_siren   <= 1'b0;
      r_armed   <= 1'b0;
      r_wait    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bypass  <= w_bypass_nxt;
      r_latched <= w_latch_nxt;
      r_siren   <= (w_state_nxt == StAlarm);
      r_armed   <= (w_state_nxt != StDisarmed);
      r_wait    <= (w_state_nxt == StExitWait) || (w_state_nxt == StEntryWait);
    end
  end

  assign alarm_siren   = r_siren;
  assign is_armed      = r_armed;
  assign is_wait_delay = r_wait;
  assign zone_latched  = r_latched;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Self-checking bench for alarm_zone_ctrl: directed scenarios plus random stimulus against a
// behavioural model. Tamper scenario is built only with ALARM_TAMPER_EN.
module tb_alarm_zone_ctrl;

  localparam int DIV     = 4;
  localparam int EXIT_D  = 3;
  localparam int ENTRY_D = 2;
  localparam int SIREN_T = 5;
  localparam logic [3:0] CODE = 4'hA;
  localparam logic [2:0] INST = 3'b001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] sensors_in = '0;
  logic       keypad_valid = 1'b0;
  logic [3:0] keypad_code = '0;
`ifdef ALARM_TAMPER_EN
  logic       tamper_in = 1'b0;
`endif
  logic       alarm_siren, is_armed, is_wait_delay, tick;
  logic [2:0] zone_latched;
  logic [6:0] obs;

  assign obs = {alarm_siren, is_armed, is_wait_delay, zone_latched, tick};

  alarm_zone_ctrl #(
    .NUM_ZONES   (3),
    .CLK_DIV     (DIV),
    .CODE_W      (4),
    .ARM_CODE    (CODE),
    .INSTANT_MASK(INST),
    .TIMER_W     (8),
    .EXIT_DELAY  (EXIT_D),
    .ENTRY_DELAY (ENTRY_D),
    .SIREN_TIME  (SIREN_T)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sensors_in   (sensors_in),
    .keypad_valid (keypad_valid),
    .keypad_code  (keypad_code),
`ifdef ALARM_TAMPER_EN
    .tamper_in    (tamper_in),
`endif
    .alarm_siren  (alarm_siren),
    .is_armed     (is_armed),
    .is_wait_delay(is_wait_delay),
    .zone_latched (zone_latched),
    .tick         (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural model: modes, ticks remaining, and a two-deep delay line for the sensors.
  typedef enum {M_OFF, M_LEAVING, M_ON, M_ENTERING, M_SOUNDING} mode_t;
  mode_t      m_mode;
  int         m_left;
  int         m_cyc;
  logic [2:0] m_s1, m_s2, m_byp, m_lat;
  logic       m_t1, m_t2;

  int n_checks = 0;
  int n_errs   = 0;

  function automatic logic [6:0] m_exp();
    logic s, a, w, t;
    s = (m_mode == M_SOUNDING);
    a = (m_mode != M_OFF);
    w = (m_mode == M_LEAVING) || (m_mode == M_ENTERING);
    t = ((m_cyc % DIV) == DIV - 1);
    return {s, a, w, m_lat, t};
  endfunction

  task automatic model_edge();
    logic       tk, code, inst, dly, tmp;
    logic [2:0] live, nb, nlat;
    mode_t      nm;
    int         nl;
    if (reset) begin
      m_mode = M_OFF; m_left = 0; m_cyc = 0;
      m_s1 = '0; m_s2 = '0; m_byp = '0; m_lat = '0; m_t1 = 1'b0; m_t2 = 1'b0;
      return;
    end
    tk   = ((m_cyc % DIV) == DIV - 1);
    code = keypad_valid && (keypad_code == CODE);
    live = m_s2 & ~m_byp;
    inst = |(live & INST);
    dly  = |(live & ~INST);
    tmp  = m_t2;
    nm = m_mode; nl = m_left; nb = m_byp & m_s2; nlat = m_lat;
    if (m_mode == M_ON || m_mode == M_ENTERING || m_mode == M_SOUNDING) nlat = m_lat | live;
    if (tmp) begin
      nm = M_SOUNDING; nl = SIREN_T;
    end else if (code) begin
      if (m_mode == M_OFF) begin
        nm = M_LEAVING; nl = EXIT_D; nlat = '0; nb = '0;
      end else begin
        nm = M_OFF;
      end
    end else begin
      case (m_mode)
        M_LEAVING: if (tk) begin nl = m_left - 1; if (nl == 0) nm = M_ON; end
        M_ON: begin
          if (inst) begin nm = M_SOUNDING; nl = SIREN_T; end
          else if (dly) begin nm = M_ENTERING; nl = ENTRY_D; end
        end
        M_ENTERING: begin
          if (inst) begin nm = M_SOUNDING; nl = SIREN_T; end
          else if (tk) begin
            nl = m_left - 1;
            if (nl == 0) begin nm = M_SOUNDING; nl = SIREN_T; end
          end
        end
        M_SOUNDING: if (tk) begin nl = m_left - 1; if (nl == 0) nm = M_ON; end
        default: ;
      endcase
    end
    if (m_mode == M_SOUNDING) nb = m_s2;
    m_mode = nm; m_left = nl; m_byp = nb; m_lat = nlat;
    m_s2 = m_s1; m_s1 = sensors_in;
    m_t2 = m_t1;
`ifdef ALARM_TAMPER_EN
    m_t1 = tamper_in;
`else
    m_t1 = 1'b0;
`endif
    m_cyc++;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    keypad_valid = 1'b1;
    keypad_code  = c;
    cycle();
    keypad_valid = 1'b0;
    keypad_code  = '0;
  endtask

  // Leaves the system freshly armed: exit delay expires at most EXIT_D*DIV edges after the strobe.
  task automatic arm_fresh();
    if (m_mode != M_OFF) press(CODE);
    press(CODE);
    repeat (EXIT_D * DIV) cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (obs !== 7'b0) begin
      n_errs++; $display("FAIL reset_outputs got=%b want=%b", obs, 7'b0);
    end
    reset = 1'b0;
    cycle();
    n_checks++;
    if (obs !== m_exp()) begin
      n_errs++; $display("FAIL reset_release got=%b want=%b", obs, m_exp());
    end
  endtask

  task automatic test_arm();
    int n;
    press(4'h5);
    n_checks++;
    if (is_armed !== 1'b0) begin
      n_errs++; $display("FAIL wrong_code got=%b want=0", is_armed);
    end
    press(CODE);
    n_checks++;
    if ({is_armed, is_wait_delay} !== 2'b11) begin
      n_errs++; $display("FAIL arm_strobe got=%b want=11", {is_armed, is_wait_delay});
    end
    n = 0;
    while (!(is_armed && !is_wait_delay) && n < 40) begin
      cycle();
      n++;
      n_checks++;
      if (obs !== m_exp()) begin
        n_errs++; $display("FAIL exit_seq cyc=%0d got=%b want=%b", n, obs, m_exp());
      end
    end
    n_checks++;
    if (n < (EXIT_D - 1) * DIV + 1 || n > EXIT_D * DIV) begin
      n_errs++; $display("FAIL exit_delay got=%0d cycles want=%0d..%0d", n,
                         (EXIT_D - 1) * DIV + 1, EXIT_D * DIV);
    end
    n_checks++;
    if (zone_latched !== 3'b000) begin
      n_errs++; $display("FAIL arm_latched got=%b want=000", zone_latched);
    end
  endtask

  task automatic test_instant();
    int n;
    sensors_in = 3'b001;
    repeat (3) cycle();
    sensors_in = 3'b000;
    n_checks++;
    if ({alarm_siren, zone_latched} !== 4'b1001) begin
      n_errs++; $display("FAIL instant_trip got=%b want=1001", {alarm_siren, zone_latched});
    end
    n = 0;
    while (alarm_siren && n < 60) begin
      cycle();
      n++;
      n_checks++;
      if (obs !== m_exp()) begin
        n_errs++; $display("FAIL siren_seq cyc=%0d got=%b want=%b", n, obs, m_exp());
      end
    end
    n_checks++;
    if ({alarm_siren, is_armed, is_wait_delay} !== 3'b010) begin
      n_errs++; $display("FAIL siren_rearm got=%b want=010", {alarm_siren, is_armed, is_wait_delay});
    end
  endtask

  task automatic test_entry();
    int n;
    arm_fresh();
    n_checks++;
    if ({is_armed, is_wait_delay, zone_latched} !== 5'b10000) begin
      n_errs++; $display("FAIL entry_setup got=%b want=10000", {is_armed, is_wait_delay, zone_latched});
    end
    sensors_in = 3'b010;
    repeat (3) cycle();
    sensors_in = 3'b000;
    n_checks++;
    if ({is_armed, is_wait_delay, alarm_siren} !== 3'b110) begin
      n_errs++; $display("FAIL entry_start got=%b want=110", {is_armed, is_wait_delay, alarm_siren});
    end
    press(CODE);
    n_checks++;
    if ({alarm_siren, is_armed, zone_latched} !== 5'b00010) begin
      n_errs++; $display("FAIL entry_disarm got=%b want=00010", {alarm_siren, is_armed, zone_latched});
    end
    arm_fresh();
    sensors_in = 3'b010;
    repeat (3) cycle();
    sensors_in = 3'b000;
    n = 0;
    while (!alarm_siren && n < 20) begin
      cycle();
      n++;
      n_checks++;
      if (obs !== m_exp()) begin
        n_errs++; $display("FAIL entry_seq cyc=%0d got=%b want=%b", n, obs, m_exp());
      end
    end
    n_checks++;
    if (!alarm_siren || n < (ENTRY_D - 1) * DIV + 1 || n > ENTRY_D * DIV) begin
      n_errs++; $display("FAIL entry_expiry siren=%b after %0d cycles want 1 after %0d..%0d",
                         alarm_siren, n, (ENTRY_D - 1) * DIV + 1, ENTRY_D * DIV);
    end
  endtask

  task automatic test_bypass();
    logic saw_siren;
    arm_fresh();
    sensors_in = 3'b100;
    saw_siren = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      saw_siren |= alarm_siren;
      n_checks++;
      if (obs !== m_exp()) begin
        n_errs++; $display("FAIL bypass_seq cyc=%0d got=%b want=%b", i, obs, m_exp());
      end
    end
    n_checks++;
    if ({saw_siren, alarm_siren, is_armed, is_wait_delay} !== 4'b1010) begin
      n_errs++; $display("FAIL bypass_hold got=%b want=1010",
                         {saw_siren, alarm_siren, is_armed, is_wait_delay});
    end
    sensors_in = 3'b000;
    cycle();
    sensors_in = 3'b100;
    repeat (3) cycle();
    n_checks++;
    if ({is_armed, is_wait_delay, alarm_siren} !== 3'b110) begin
      n_errs++; $display("FAIL bypass_release got=%b want=110", {is_armed, is_wait_delay, alarm_siren});
    end
    sensors_in = 3'b000;
    press(CODE);
  endtask

  task automatic test_same_cycle();
    arm_fresh();
    sensors_in = 3'b010;
    cycle();
    sensors_in = 3'b011;
    repeat (2) cycle();
    n_checks++;
    if ({is_wait_delay, alarm_siren} !== 2'b10) begin
      n_errs++; $display("FAIL tie_setup got=%b want=10", {is_wait_delay, alarm_siren});
    end
    press(CODE);
    sensors_in = 3'b000;
    n_checks++;
    if ({alarm_siren, is_armed, is_wait_delay} !== 3'b000) begin
      n_errs++; $display("FAIL code_beats_instant got=%b want=000",
                         {alarm_siren, is_armed, is_wait_delay});
    end
    repeat (3) cycle();
    arm_fresh();
    sensors_in = 3'b001;
    repeat (3) cycle();
    n_checks++;
    if (alarm_siren !== 1'b1) begin
      n_errs++; $display("FAIL pre_reset_alarm got=%b want=1", alarm_siren);
    end
    reset = 1'b1;
    keypad_valid = 1'b1;
    keypad_code = CODE;
    cycle();
    n_checks++;
    if (obs[6:1] !== 6'b0) begin
      n_errs++; $display("FAIL reset_in_alarm got=%b want=000000", obs[6:1]);
    end
    reset = 1'b0;
    keypad_valid = 1'b0;
    sensors_in = 3'b000;
    cycle();
    n_checks++;
    if (obs !== m_exp() || is_armed !== 1'b0) begin
      n_errs++; $display("FAIL reset_strobe_dropped got=%b want=%b", obs, m_exp());
    end
  endtask

`ifdef ALARM_TAMPER_EN
  task automatic test_tamper();
    int n;
    tamper_in = 1'b1;
    repeat (3) cycle();
    n_checks++;
    if ({alarm_siren, is_armed} !== 2'b11) begin
      n_errs++; $display("FAIL tamper_alarm got=%b want=11", {alarm_siren, is_armed});
    end
    press(CODE);
    n_checks++;
    if ({alarm_siren, is_armed} !== 2'b11) begin
      n_errs++; $display("FAIL tamper_code_ignored got=%b want=11", {alarm_siren, is_armed});
    end
    tamper_in = 1'b0;
    n = 0;
    while (alarm_siren && n < 60) begin
      cycle();
      n++;
      n_checks++;
      if (obs !== m_exp()) begin
        n_errs++; $display("FAIL tamper_seq cyc=%0d got=%b want=%b", n, obs, m_exp());
      end
    end
    press(CODE);
    n_checks++;
    if (is_armed !== 1'b0) begin
      n_errs++; $display("FAIL tamper_disarm got=%b want=0", is_armed);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int z = 0; z < 3; z++) begin
        if ($urandom_range(0, 11) == 0) sensors_in[z] = ~sensors_in[z];
      end
      keypad_valid = ($urandom_range(0, 9) == 0);
      keypad_code  = ($urandom_range(0, 1) == 0) ? CODE : 4'($urandom);
      reset        = ($urandom_range(0, 249) == 0);
      cycle();
      n_checks++;
      if (obs !== m_exp()) begin
        n_errs++; $display("FAIL random cyc=%0d got=%b want=%b", i, obs, m_exp());
      end
    end
    reset = 1'b0;
    keypad_valid = 1'b0;
    sensors_in = 3'b000;
  endtask

  initial begin
    test_reset();
    test_arm();
    test_instant();
    test_entry();
    test_bypass();
    test_same_cycle();
`ifdef ALARM_TAMPER_EN
    test_tamper();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
